// File: rtl/cr_huf_comp_htb_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : cr_huf_comp_htb_dispatch
// Purpose  : Dispatches short-tree build requests to two builder pipes with
//            round-robin grant. Tracks per-pipe IDLE/BUSY/DONE state and keeps
//            an in-order completion FIFO so trees drain in request order.
// Ports    : clk, rst                      - clock, sync active-high reset
//            req_valid/req_seq_id/req_ready - request handshake from sorter
//            disable_second_pipe            - masks pipe 2 from new grants
//            p1/p2_not_ready                - builder backpressure
//            p1/p2_start, start_seq_id      - registered start pulse + id
//            p1/p2_done                     - builder completion pulses
//            ord_valid/ord_pipe/ord_seq_id  - head of completion order
//            ord_pop                        - header writer consumed head
//            err_done                       - done seen from a non-BUSY pipe
// Revision : 1.0 - initial release
// ============================================================================
module cr_huf_comp_htb_dispatch #(
  parameter int SEQ_W       = 4,
  parameter int ORD_DEPTH   = 4,
  parameter int SINGLE_PIPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEQ_W-1:0] req_seq_id,
  output logic             req_ready,
  input  logic             disable_second_pipe,
  input  logic             p1_not_ready,
  input  logic             p2_not_ready,
  output logic             p1_start,
  output logic             p2_start,
  output logic [SEQ_W-1:0] start_seq_id,
  input  logic             p1_done,
  input  logic             p2_done,
  output logic             ord_valid,
  output logic             ord_pipe,
  output logic [SEQ_W-1:0] ord_seq_id,
  input  logic             ord_pop,
  output logic             err_done
);

  localparam int PTR_W = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       st1_q, st2_q, st1_d, st2_d;
  logic             last_grant;  // 1 = pipe 2 was granted most recently
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SEQ_W:0]   ord_mem [ORD_DEPTH];  // {pipe, seq_id}

  logic             pipe2_allowed;
  logic             avail1, avail2, ord_full, ord_empty;
  logic             accept, grant2, pop, err_d;
  logic             head_pipe, head_done;
  logic [SEQ_W-1:0] head_seq;

  generate
    if (SINGLE_PIPE != 0) begin : g_single_pipe
      assign pipe2_allowed = 1'b0;
    end else begin : g_dual_pipe
      assign pipe2_allowed = 1'b1;
    end
  endgenerate

  // State register: per-pipe FSMs, order FIFO, grant history, output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      st1_q        <= ST_IDLE;
      st2_q        <= ST_IDLE;
      last_grant   <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      p1_start     <= 1'b0;
      p2_start     <= 1'b0;
      start_seq_id <= '0;
      err_done     <= 1'b0;
    end else begin
      st1_q    <= st1_d;
      st2_q    <= st2_d;
      p1_start <= accept & ~grant2;
      p2_start <= accept & grant2;
      err_done <= err_d;
      if (accept) begin
        last_grant   <= grant2;
        start_seq_id <= req_seq_id;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // FIFO storage needs no reset; head fields are masked while empty
  always_ff @(posedge clk) begin
    if (accept) begin
      ord_mem[wr_ptr] <= {grant2, req_seq_id};
    end
  end

  // Next-state logic
  always_comb begin
    st1_d = st1_q;
    st2_d = st2_q;
    case (st1_q)
      ST_IDLE: if (accept && !grant2)       st1_d = ST_BUSY;
      ST_BUSY: if (p1_done)                 st1_d = ST_DONE;
      ST_DONE: if (pop && !head_pipe)       st1_d = ST_IDLE;
      default:                              st1_d = ST_IDLE;
    endcase
    case (st2_q)
      ST_IDLE: if (accept && grant2)        st2_d = ST_BUSY;
      ST_BUSY: if (p2_done)                 st2_d = ST_DONE;
      ST_DONE: if (pop && head_pipe)        st2_d = ST_IDLE;
      default:                              st2_d = ST_IDLE;
    endcase
    err_d = (p1_done && (st1_q != ST_BUSY)) || (p2_done && (st2_q != ST_BUSY));
  end

  // Output / handshake logic
  always_comb begin
    avail1    = (st1_q == ST_IDLE) && !p1_not_ready;
    avail2    = (st2_q == ST_IDLE) && !p2_not_ready && !disable_second_pipe && pipe2_allowed;
    ord_full  = (count == CNT_W'(ORD_DEPTH));
    ord_empty = (count == '0);
    req_ready = !rst && (avail1 || avail2) && !ord_full;
    accept    = req_valid && req_ready;
    // With both pipes free, alternate away from the most recent grant
    grant2    = avail2 && (!avail1 || !last_grant);
    head_pipe = ord_mem[rd_ptr][SEQ_W];
    head_seq  = ord_mem[rd_ptr][SEQ_W-1:0];
    head_done = head_pipe ? (st2_q == ST_DONE) : (st1_q == ST_DONE);
    ord_valid = !ord_empty && head_done;
    ord_pipe  = !ord_empty && head_pipe;
    ord_seq_id = ord_empty ? '0 : head_seq;
    pop       = ord_pop && ord_valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_cr_huf_comp_htb_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_huf_comp_htb_dispatch
// Purpose  : Self-checking bench for cr_huf_comp_htb_dispatch. A request-order
//            queue plus per-pipe status model predicts outputs every cycle;
//            directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_huf_comp_htb_dispatch;

  localparam int SEQ_W     = 4;
  localparam int ORD_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [SEQ_W-1:0] req_seq_id = '0;
  logic             req_ready;
  logic             disable_second_pipe = 1'b0;
  logic             p1_not_ready = 1'b0;
  logic             p2_not_ready = 1'b0;
  logic             p1_start, p2_start;
  logic [SEQ_W-1:0] start_seq_id;
  logic             p1_done = 1'b0;
  logic             p2_done = 1'b0;
  logic             ord_valid, ord_pipe;
  logic [SEQ_W-1:0] ord_seq_id;
  logic             ord_pop = 1'b0;
  logic             err_done;

  cr_huf_comp_htb_dispatch #(
    .SEQ_W(SEQ_W), .ORD_DEPTH(ORD_DEPTH), .SINGLE_PIPE(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_seq_id(req_seq_id), .req_ready(req_ready),
    .disable_second_pipe(disable_second_pipe),
    .p1_not_ready(p1_not_ready), .p2_not_ready(p2_not_ready),
    .p1_start(p1_start), .p2_start(p2_start), .start_seq_id(start_seq_id),
    .p1_done(p1_done), .p2_done(p2_done),
    .ord_valid(ord_valid), .ord_pipe(ord_pipe), .ord_seq_id(ord_seq_id),
    .ord_pop(ord_pop), .err_done(err_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // pipe status: 0 idle, 1 building, 2 finished; index 0 = pipe 1
  int             mst [2] = '{0, 0};
  logic [SEQ_W:0] q [$];          // {pipe, seq} in request order
  bit             m_last2 = 1'b1;  // pipe 2 granted most recently
  bit             e_p1s = 0, e_p2s = 0, e_err = 0;
  logic [SEQ_W-1:0] e_sid = '0;
  bit             ma1, ma2, e_ready, e_ovalid, mw;
  int             pre0, pre1;

  always @(negedge clk) begin
    ma1      = (mst[0] == 0) && !p1_not_ready;
    ma2      = (mst[1] == 0) && !p2_not_ready && !disable_second_pipe;
    e_ready  = !rst && (ma1 || ma2) && (q.size() < ORD_DEPTH);
    e_ovalid = (q.size() > 0) && (mst[int'(q[0][SEQ_W])] == 2);
    chk("m_req_ready", 32'(req_ready), 32'(e_ready));
    chk("m_ord_valid", 32'(ord_valid), 32'(e_ovalid));
    if (e_ovalid) begin
      chk("m_ord_pipe",   32'(ord_pipe),   32'(q[0][SEQ_W]));
      chk("m_ord_seq_id", 32'(ord_seq_id), 32'(q[0][SEQ_W-1:0]));
    end
    chk("m_p1_start", 32'(p1_start), 32'(e_p1s));
    chk("m_p2_start", 32'(p2_start), 32'(e_p2s));
    if (e_p1s || e_p2s) chk("m_start_seq_id", 32'(start_seq_id), 32'(e_sid));
    chk("m_err_done", 32'(err_done), 32'(e_err));

    // advance the model across the coming rising edge
    if (rst) begin
      mst = '{0, 0};
      q.delete();
      m_last2 = 1'b1;
      e_p1s = 0; e_p2s = 0; e_err = 0;
    end else begin
      pre0  = mst[0];
      pre1  = mst[1];
      e_err = (p1_done && pre0 != 1) || (p2_done && pre1 != 1);
      if (p1_done && pre0 == 1) mst[0] = 2;
      if (p2_done && pre1 == 1) mst[1] = 2;
      if (ord_pop && e_ovalid) begin
        mst[int'(q[0][SEQ_W])] = 0;
        void'(q.pop_front());
      end
      e_p1s = 0; e_p2s = 0;
      if (req_valid && e_ready) begin
        mw = (ma1 && ma2) ? !m_last2 : !ma1;
        mst[int'(mw)] = 1;
        q.push_back({mw, req_seq_id});
        m_last2 = mw;
        e_p1s = !mw; e_p2s = mw;
        e_sid = req_seq_id;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nx();
    @(posedge clk); #1;
  endtask

  initial begin
    nx(); nx();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ord_valid", 32'(ord_valid), 32'd0);
    chk("rst_ord_pipe", 32'(ord_pipe), 32'd0);
    chk("rst_ord_seq", 32'(ord_seq_id), 32'd0);
    chk("rst_p1_start", 32'(p1_start), 32'd0);
    chk("rst_p2_start", 32'(p2_start), 32'd0);
    chk("rst_start_seq", 32'(start_seq_id), 32'd0);
    chk("rst_err", 32'(err_done), 32'd0);
    nx();

    // 1: two requests, out-of-order completion, in-order drain
    req_valid = 1; req_seq_id = 3;
    @(negedge clk); chk("t1_ready", 32'(req_ready), 32'd1); nx();
    req_seq_id = 4;
    @(negedge clk); chk("t1_p1_start", 32'(p1_start), 32'd1);
    chk("t1_sid3", 32'(start_seq_id), 32'd3); nx();
    req_valid = 0;
    @(negedge clk); chk("t1_p2_start", 32'(p2_start), 32'd1);
    chk("t1_sid4", 32'(start_seq_id), 32'd4); nx();
    p2_done = 1;
    @(negedge clk); chk("t1_wait_p1", 32'(ord_valid), 32'd0); nx();
    p2_done = 0; p1_done = 1;
    @(negedge clk); chk("t1_still_wait", 32'(ord_valid), 32'd0); nx();
    p1_done = 0; ord_pop = 1;
    @(negedge clk); chk("t1_head_valid", 32'(ord_valid), 32'd1);
    chk("t1_head_pipe0", 32'(ord_pipe), 32'd0);
    chk("t1_head_id3", 32'(ord_seq_id), 32'd3); nx();
    @(negedge clk); chk("t1_head_pipe1", 32'(ord_pipe), 32'd1);
    chk("t1_head_id4", 32'(ord_seq_id), 32'd4); nx();
    // pop while empty is ignored
    @(negedge clk); chk("t1_empty", 32'(ord_valid), 32'd0); nx();
    ord_pop = 0;

    // 4: done from an idle pipe
    p1_done = 1; nx(); p1_done = 0;
    @(negedge clk); chk("t4_err_pulse", 32'(err_done), 32'd1);
    chk("t4_no_valid", 32'(ord_valid), 32'd0); nx();
    @(negedge clk); chk("t4_err_clear", 32'(err_done), 32'd0); nx();

    // 2: second pipe disabled
    disable_second_pipe = 1; req_valid = 1; req_seq_id = 5;
    nx();
    req_seq_id = 6;
    @(negedge clk); chk("t2_p1_id5", 32'(p1_start), 32'd1);
    chk("t2_blocked", 32'(req_ready), 32'd0); nx();
    p1_done = 1; nx();
    p1_done = 0; ord_pop = 1;
    @(negedge clk); chk("t2_pop_id5", 32'(ord_seq_id), 32'd5);
    chk("t2_still_blocked", 32'(req_ready), 32'd0); nx();
    ord_pop = 0;
    @(negedge clk); chk("t2_ready_again", 32'(req_ready), 32'd1); nx();
    req_valid = 0;
    @(negedge clk); chk("t2_p1_id6", 32'(p1_start), 32'd1);
    chk("t2_sid6", 32'(start_seq_id), 32'd6); nx();
    p1_done = 1; nx(); p1_done = 0; ord_pop = 1; nx(); ord_pop = 0;
    disable_second_pipe = 0;

    // 3: both pipes finished, then a same-cycle push and pop
    req_valid = 1; req_seq_id = 7; nx();
    req_seq_id = 8;
    @(negedge clk); chk("t3_p2_id7", 32'(p2_start), 32'd1); nx();
    req_valid = 0;
    @(negedge clk); chk("t3_p1_id8", 32'(p1_start), 32'd1); nx();
    p1_done = 1; p2_done = 1; nx();
    p1_done = 0; p2_done = 0; req_valid = 1; req_seq_id = 9;
    @(negedge clk); chk("t3_full_pipes", 32'(req_ready), 32'd0);
    chk("t3_head_id7", 32'(ord_seq_id), 32'd7); nx();
    req_valid = 0; ord_pop = 1; nx();
    req_valid = 1; req_seq_id = 9;
    @(negedge clk); chk("t3_push_ready", 32'(req_ready), 32'd1);
    chk("t3_head_id8", 32'(ord_seq_id), 32'd8); nx();
    req_valid = 0; ord_pop = 0;
    @(negedge clk); chk("t3_p2_id9", 32'(p2_start), 32'd1);
    chk("t3_head_busy", 32'(ord_valid), 32'd0); nx();
    p2_done = 1; nx(); p2_done = 0; ord_pop = 1;
    @(negedge clk); chk("t3_head_id9", 32'(ord_seq_id), 32'd9); nx();
    ord_pop = 0;

    // 5: reset with both pipes building
    req_valid = 1; req_seq_id = 10; nx();
    req_seq_id = 11; nx();
    req_valid = 0; nx();
    rst = 1; nx();
    rst = 0; req_valid = 1; req_seq_id = 12;
    @(negedge clk); chk("t5_cleared", 32'(ord_valid), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd1); nx();
    req_valid = 0;
    @(negedge clk); chk("t5_p1_first", 32'(p1_start), 32'd1);
    chk("t5_sid12", 32'(start_seq_id), 32'd12); nx();

    // 6: pipe 2 backpressure while pipe 1 busy
    p2_not_ready = 1; req_valid = 1; req_seq_id = 13;
    @(negedge clk); chk("t6_backpressure", 32'(req_ready), 32'd0); nx();
    p2_not_ready = 0;
    @(negedge clk); chk("t6_released", 32'(req_ready), 32'd1); nx();
    req_valid = 0; p1_done = 1; p2_done = 1;  // done in the start cycle is legal
    @(negedge clk); chk("t6_p2_id13", 32'(p2_start), 32'd1); nx();
    p1_done = 0; p2_done = 0; ord_pop = 1;
    @(negedge clk); chk("t6_head_id12", 32'(ord_seq_id), 32'd12);
    chk("t6_no_err", 32'(err_done), 32'd0); nx();
    @(negedge clk); chk("t6_head_id13", 32'(ord_seq_id), 32'd13); nx();
    ord_pop = 0;
    @(negedge clk); chk("t6_drained", 32'(ord_valid), 32'd0); nx();
    nx();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
